// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stage enables/flushes and counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             mem_busy;
    logic             ex_div_start;
    logic             ex_branch_taken;
    logic             idex_mem_read;
    logic [4:0]       idex_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             div_result_valid;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    // Pipeline datapath side: reports status, consumes controls.
    modport master (
        output mem_busy, ex_div_start, ex_branch_taken, idex_mem_read, idex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               exmem_flush, div_result_valid, stall_count, flush_count
    );

    // Controller side.
    modport slave (
        input  mem_busy, ex_div_start, ex_branch_taken, idex_mem_read, idex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               exmem_flush, div_result_valid, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline. Priority per cycle:
// memory wait > divider occupancy > taken branch > load-use hazard.
module pipeline_hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {RUN, DIV, DIV_DONE} state_e;

    localparam int               DCW      = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [DCW-1:0]   DIV_LOAD = DCW'(DIV_CYCLES - 2);

    state_e           state_q, state_d;
    logic [DCW-1:0]   cnt_q, cnt_d, cnt_dec;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

    logic load_use, br_flush;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, div_vld;

    // Decode hazards and next state; outputs depend on state and live inputs.
    always_comb begin
        load_use = hz.idex_mem_read && (hz.idex_rd != 5'd0) &&
                   ((hz.id_use_rs1 && (hz.id_rs1 == hz.idex_rd)) ||
                    (hz.id_use_rs2 && (hz.id_rs2 == hz.idex_rd)));
        // Divider countdown runs even while memory freezes the pipeline.
        cnt_dec     = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        cnt_d       = cnt_dec;
        state_d     = state_q;
        br_flush    = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        div_vld     = 1'b0;
        if (!reset) begin
            {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
        end else if (hz.mem_busy) begin
            {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hz.ex_div_start) begin
                        {pc_en, ifid_en, idex_en} = 3'b000;
                        exmem_flush = 1'b1;
                        cnt_d       = DIV_LOAD;
                        // Two-cycle divide has no countdown phase.
                        state_d     = (DIV_LOAD == '0) ? DIV_DONE : DIV;
                    end else if (hz.ex_branch_taken) begin
                        // Branch squashes the younger consumer, so any load-use is moot.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        br_flush   = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                DIV: begin
                    {pc_en, ifid_en, idex_en} = 3'b000;
                    exmem_flush = 1'b1;
                    // Leave when the countdown lands on zero (or was already
                    // drained during a memory wait).
                    if (cnt_dec == '0) state_d = DIV_DONE;
                end
                DIV_DONE: begin
                    div_vld = 1'b1;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
        stall_d = stall_q + {{(CNT_W-1){1'b0}}, ~pc_en};
        flush_d = flush_q + {{(CNT_W-1){1'b0}}, br_flush};
    end

    // State, divider countdown and performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign hz.pc_en            = pc_en;
    assign hz.ifid_en          = ifid_en;
    assign hz.ifid_flush       = ifid_flush;
    assign hz.idex_en          = idex_en;
    assign hz.idex_flush       = idex_flush;
    assign hz.exmem_en         = exmem_en;
    assign hz.exmem_flush      = exmem_flush;
    assign hz.div_result_valid = div_vld;
    assign hz.stall_count      = stall_q;
    assign hz.flush_count      = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for the hazard controller: reset, load-use, divide timing,
// memory waits, branch flush, counter wrap and asynchronous reset.
module tb_pipeline_hazard_ctrl;
    localparam int CW = 8;

    // Control word order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    // exmem_en, exmem_flush, div_result_valid.
    localparam logic [7:0] C_RST  = 8'b0010_1010;
    localparam logic [7:0] C_IDLE = 8'b1101_0100;
    localparam logic [7:0] C_LU   = 8'b0001_1100;
    localparam logic [7:0] C_DIV  = 8'b0000_0110;
    localparam logic [7:0] C_DONE = 8'b1101_0101;
    localparam logic [7:0] C_BR   = 8'b1111_1100;
    localparam logic [7:0] C_BUSY = 8'b0000_0000;

    logic clk, reset;
    int   nvec, nerr;
    logic [7:0] ctl;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) dif ();

    pipeline_hazard_ctrl #(.DIV_CYCLES(32), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (dif.slave)
    );

    assign ctl = {dif.pc_en, dif.ifid_en, dif.ifid_flush, dif.idex_en, dif.idex_flush,
                  dif.exmem_en, dif.exmem_flush, dif.div_result_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divide and branch in the same EX cycle cannot occur in a legal pipeline.
    always @(posedge clk)
        if (reset) assert (!(dif.ex_div_start && dif.ex_branch_taken))
            else $error("illegal div and branch together");

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dif.mem_busy        = 1'b0;
        dif.ex_div_start    = 1'b0;
        dif.ex_branch_taken = 1'b0;
        dif.idex_mem_read   = 1'b0;
        dif.idex_rd         = 5'd0;
        dif.id_rs1          = 5'd0;
        dif.id_rs2          = 5'd0;
        dif.id_use_rs1      = 1'b0;
        dif.id_use_rs2      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (ctl !== C_RST) begin nerr++; $display("FAIL rst_ctl got %b want %b", ctl, C_RST); end
        nvec++; if (dif.stall_count !== 8'd0) begin nerr++; $display("FAIL rst_stall got %0d want 0", dif.stall_count); end
        nvec++; if (dif.flush_count !== 8'd0) begin nerr++; $display("FAIL rst_flush got %0d want 0", dif.flush_count); end
        reset = 1'b1;
        step();
        nvec++; if (ctl !== C_IDLE) begin nerr++; $display("FAIL rel_ctl got %b want %b", ctl, C_IDLE); end
        nvec++; if (dif.stall_count !== 8'd0) begin nerr++; $display("FAIL rel_stall got %0d want 0", dif.stall_count); end
        nvec++; if (dif.flush_count !== 8'd0) begin nerr++; $display("FAIL rel_flush got %0d want 0", dif.flush_count); end
    endtask

    task automatic test_load_use();
        dif.idex_mem_read = 1'b1; dif.idex_rd = 5'd5;
        dif.id_rs1 = 5'd3; dif.id_use_rs1 = 1'b1;
        dif.id_rs2 = 5'd5; dif.id_use_rs2 = 1'b1;
        #2;
        nvec++; if (ctl !== C_LU) begin nerr++; $display("FAIL lu_rs2 got %b want %b", ctl, C_LU); end
        step(); idle_inputs(); #2;
        nvec++; if (ctl !== C_IDLE) begin nerr++; $display("FAIL lu_after got %b want %b", ctl, C_IDLE); end
        nvec++; if (dif.stall_count !== 8'd1) begin nerr++; $display("FAIL lu_stall got %0d want 1", dif.stall_count); end
        // x0 destination never creates a hazard.
        dif.idex_mem_read = 1'b1; dif.idex_rd = 5'd0; dif.id_use_rs2 = 1'b1;
        #1;
        nvec++; if (ctl !== C_IDLE) begin nerr++; $display("FAIL lu_x0 got %b want %b", ctl, C_IDLE); end
        step();
        // Matching rs1 that the instruction does not read.
        dif.idex_rd = 5'd7; dif.id_rs1 = 5'd7; dif.id_use_rs1 = 1'b0; dif.id_rs2 = 5'd1;
        #1;
        nvec++; if (ctl !== C_IDLE) begin nerr++; $display("FAIL lu_unused got %b want %b", ctl, C_IDLE); end
        step();
        dif.id_use_rs1 = 1'b1;
        #1;
        nvec++; if (ctl !== C_LU) begin nerr++; $display("FAIL lu_rs1 got %b want %b", ctl, C_LU); end
        step(); idle_inputs(); #1;
        nvec++; if (dif.stall_count !== 8'd2) begin nerr++; $display("FAIL lu_stall2 got %0d want 2", dif.stall_count); end
    endtask

    task automatic test_div(input int busy_lo, input int busy_hi, input int done_cyc,
                            input logic [7:0] exp_stall);
        logic [7:0] exp;
        dif.ex_div_start = 1'b1;
        for (int c = 1; c <= done_cyc; c++) begin
            dif.mem_busy = (c >= busy_lo) && (c <= busy_hi);
            #2;
            exp = dif.mem_busy ? C_BUSY : (c == done_cyc) ? C_DONE : C_DIV;
            nvec++; if (ctl !== exp) begin nerr++; $display("FAIL div_cyc%0d got %b want %b", c, ctl, exp); end
            step();
        end
        idle_inputs(); #2;
        nvec++; if (ctl !== C_IDLE) begin nerr++; $display("FAIL div_run got %b want %b", ctl, C_IDLE); end
        nvec++; if (dif.stall_count !== exp_stall) begin nerr++; $display("FAIL div_stall got %0d want %0d", dif.stall_count, exp_stall); end
    endtask

    task automatic test_branch_load_use();
        dif.ex_branch_taken = 1'b1;
        dif.idex_mem_read = 1'b1; dif.idex_rd = 5'd5; dif.id_rs2 = 5'd5; dif.id_use_rs2 = 1'b1;
        #2;
        nvec++; if (ctl !== C_BR) begin nerr++; $display("FAIL br_lu got %b want %b", ctl, C_BR); end
        step(); idle_inputs(); #2;
        nvec++; if (dif.flush_count !== 8'd1) begin nerr++; $display("FAIL br_flush got %0d want 1", dif.flush_count); end
        nvec++; if (dif.stall_count !== 8'd96) begin nerr++; $display("FAIL br_stall got %0d want 96", dif.stall_count); end
    endtask

    task automatic test_back_to_back();
        dif.ex_branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            nvec++; if (ctl !== C_BR) begin nerr++; $display("FAIL b2b_br%0d got %b want %b", i, ctl, C_BR); end
            step();
        end
        dif.ex_branch_taken = 1'b0;
        dif.idex_mem_read = 1'b1; dif.idex_rd = 5'd9; dif.id_rs1 = 5'd9; dif.id_use_rs1 = 1'b1;
        #2;
        nvec++; if (ctl !== C_LU) begin nerr++; $display("FAIL b2b_lu got %b want %b", ctl, C_LU); end
        step(); idle_inputs(); #2;
        nvec++; if (dif.flush_count !== 8'd3) begin nerr++; $display("FAIL b2b_flush got %0d want 3", dif.flush_count); end
        nvec++; if (dif.stall_count !== 8'd97) begin nerr++; $display("FAIL b2b_stall got %0d want 97", dif.stall_count); end
    endtask

    task automatic test_wrap();
        dif.mem_busy = 1'b1;
        #2;
        nvec++; if (ctl !== C_BUSY) begin nerr++; $display("FAIL busy_ctl got %b want %b", ctl, C_BUSY); end
        repeat (158) step();
        nvec++; if (dif.stall_count !== 8'd255) begin nerr++; $display("FAIL wrap_max got %0d want 255", dif.stall_count); end
        step();
        dif.mem_busy = 1'b0; #1;
        nvec++; if (dif.stall_count !== 8'd0) begin nerr++; $display("FAIL wrap_zero got %0d want 0", dif.stall_count); end
        nvec++; if (dif.flush_count !== 8'd3) begin nerr++; $display("FAIL wrap_flush got %0d want 3", dif.flush_count); end
    endtask

    task automatic test_async_reset();
        dif.ex_div_start = 1'b1;
        repeat (5) step();
        #1 reset = 1'b0;
        #1;
        nvec++; if (ctl !== C_RST) begin nerr++; $display("FAIL arst_ctl got %b want %b", ctl, C_RST); end
        nvec++; if (dif.stall_count !== 8'd0) begin nerr++; $display("FAIL arst_stall got %0d want 0", dif.stall_count); end
        dif.ex_div_start = 1'b0;
        step();
        reset = 1'b1; #2;
        nvec++; if (ctl !== C_IDLE) begin nerr++; $display("FAIL arst_rel got %b want %b", ctl, C_IDLE); end
        step();
        nvec++; if (ctl !== C_IDLE) begin nerr++; $display("FAIL arst_run got %b want %b", ctl, C_IDLE); end
        nvec++; if (dif.stall_count !== 8'd0) begin nerr++; $display("FAIL arst_cnt got %0d want 0", dif.stall_count); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_load_use();
        test_div(0, -1, 32, 8'd33);   // plain divide: 31 stall cycles
        test_div(10, 12, 32, 8'd64);  // memory wait mid-divide, countdown keeps running
        test_div(31, 31, 33, 8'd96);  // memory wait on the last countdown cycle delays completion
        test_branch_load_use();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
